// File: rtl/fetch_address_gen.sv
// fetch_address_gen
//
// Instruction-fetch initiator. Owns the program counter and drives the shared memory address
// bus. Load/store accesses from the memory stage take the bus for one cycle per grant. Taken
// branches redirect fetch and hold the fetch stage off for FLUSH_CYCLES cycles.
//
// Optional feature: define FETCH_HALT_EN to honour the `halt` input. When it is undefined,
// `halt` is ignored, HALTED is never entered, and the port stays in place unused.
//
// Parameters
//   RESET_PC      fetch address after reset (word aligned)
//   FLUSH_CYCLES  block_fetch cycles after a branch redirect (1..15)
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   inc_pc         in   fetch stage consumed the instruction at pc
//   branch_taken   in   one-cycle redirect pulse from execute
//   branch_target  in   redirect byte address (bits [1:0] ignored)
//   data_req       in   memory-stage bus request, held until data_grant
//   data_addr      in   load/store byte address
//   data_write     in   1 = store, 0 = load
//   halt           in   level, freezes fetch (FETCH_HALT_EN only)
//   mem_address    out  registered bus address
//   mem_write      out  registered write strobe
//   data_grant     out  registered, one cycle per data access
//   block_fetch    out  registered, fetch stage must insert a NOP
//   pc             out  address of the instruction being fetched

module fetch_address_gen #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc_pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_write,
  input  logic        halt,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic        data_grant,
  output logic        block_fetch,
  output logic [31:0] pc
);

  localparam logic [31:0] WordMask  = 32'hFFFF_FFFC;
  localparam logic [3:0]  FlushInit = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {StRun, StFlush, StData, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_write_q, mem_write_d;
  logic        data_grant_q, data_grant_d;
  logic        block_fetch_q, block_fetch_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  // Set while a data access was started from HALTED, so the block goes back there afterwards.
  logic        ret_halt_q, ret_halt_d;

  logic        halt_req;
  logic        flush_last;
  logic [31:0] target_aligned;
  logic [31:0] data_aligned;
  logic [31:0] pc_inc;

`ifdef FETCH_HALT_EN
  assign halt_req = halt;
`else
  logic unused_halt;
  assign unused_halt = halt;
  assign halt_req    = 1'b0;
`endif

  assign flush_last     = (flush_cnt_q == 4'd1);
  assign target_aligned = branch_target & WordMask;
  assign data_aligned   = data_addr & WordMask;
  assign pc_inc         = pc_q + 32'd4;

  // State register and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      mem_address_q <= RESET_PC;
      mem_write_q   <= 1'b0;
      data_grant_q  <= 1'b0;
      block_fetch_q <= 1'b0;
      flush_cnt_q   <= 4'd0;
      ret_halt_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_address_q <= mem_address_d;
      mem_write_q   <= mem_write_d;
      data_grant_q  <= data_grant_d;
      block_fetch_q <= block_fetch_d;
      flush_cnt_q   <= flush_cnt_d;
      ret_halt_q    <= ret_halt_d;
    end
  end

  // Next-state logic. Priority: branch > data_req > halt > inc_pc.
  always_comb begin
    state_d = state_q;
    if (branch_taken) begin
      state_d = StFlush;
    end else begin
      unique case (state_q)
        StRun: begin
          if (data_req)      state_d = StData;
          else if (halt_req) state_d = StHalted;
        end
        StFlush: begin
          // data_req and halt wait until RUN.
          if (flush_last) state_d = StRun;
        end
        StData: begin
          if (data_req)        state_d = StData;
          else if (ret_halt_q) state_d = StHalted;
          else                 state_d = StRun;
        end
        StHalted: begin
          if (data_req)       state_d = StData;
          else if (!halt_req) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Next values for the registered outputs and the flush counter.
  always_comb begin
    pc_d          = pc_q;
    mem_address_d = mem_address_q;
    mem_write_d   = 1'b0;
    data_grant_d  = 1'b0;
    block_fetch_d = block_fetch_q;
    flush_cnt_d   = flush_cnt_q;
    ret_halt_d    = ret_halt_q;

    if (branch_taken) begin
      // An access already on the bus completes; it just is not granted again.
      pc_d          = target_aligned;
      mem_address_d = target_aligned;
      flush_cnt_d   = FlushInit;
      block_fetch_d = 1'b1;
      ret_halt_d    = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (data_req) begin
            mem_address_d = data_aligned;
            mem_write_d   = data_write;
            data_grant_d  = 1'b1;
            block_fetch_d = 1'b1;
            ret_halt_d    = 1'b0;
          end else if (halt_req) begin
            block_fetch_d = 1'b1;
          end else begin
            block_fetch_d = 1'b0;
            if (inc_pc) begin
              pc_d          = pc_inc;
              mem_address_d = pc_inc;
            end
          end
        end
        StFlush: begin
          flush_cnt_d = flush_cnt_q - 4'd1;
          if (flush_last) block_fetch_d = 1'b0;
        end
        StData: begin
          block_fetch_d = 1'b1;
          if (data_req) begin
            mem_address_d = data_aligned;
            mem_write_d   = data_write;
            data_grant_d  = 1'b1;
          end else begin
            // One recovery cycle with the fetch address back on the bus.
            mem_address_d = pc_q;
          end
        end
        StHalted: begin
          if (data_req) begin
            mem_address_d = data_aligned;
            mem_write_d   = data_write;
            data_grant_d  = 1'b1;
            block_fetch_d = 1'b1;
            ret_halt_d    = 1'b1;
          end else begin
            block_fetch_d = halt_req;
            ret_halt_d    = 1'b0;
          end
        end
        default: begin
          block_fetch_d = 1'b0;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign mem_address = mem_address_q;
  assign mem_write   = mem_write_q;
  assign data_grant  = data_grant_q;
  assign block_fetch = block_fetch_q;

endmodule

// File: tb/tb_fetch_address_gen.sv
module tb_fetch_address_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inc_pc = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        data_req = 1'b0;
  logic [31:0] data_addr = 32'h0;
  logic        data_write = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] mem_address;
  logic        mem_write;
  logic        data_grant;
  logic        block_fetch;
  logic [31:0] pc;

  fetch_address_gen #(
    .RESET_PC    (32'h0000_0100),
    .FLUSH_CYCLES(2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .inc_pc       (inc_pc),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .data_req     (data_req),
    .data_addr    (data_addr),
    .data_write   (data_write),
    .halt         (halt),
    .mem_address  (mem_address),
    .mem_write    (mem_write),
    .data_grant   (data_grant),
    .block_fetch  (block_fetch),
    .pc           (pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        wr;
    logic        gnt;
    logic        blk;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned cycle = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always @(posedge clock) cycle <= cycle + 1;

  // Monitor: outputs are sampled at the falling edge and checked against the scoreboard.
  always @(negedge clock) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cycle) begin
      mon_e = sb_q.pop_front();
      n_cmp++;
      if (mon_e.cyc != cycle) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                 mon_e.name, mon_e.cyc, cycle);
      end else if ({pc, mem_address, mem_write, data_grant, block_fetch} !==
                   {mon_e.pc, mon_e.addr, mon_e.wr, mon_e.gnt, mon_e.blk}) begin
        n_fail++;
        $display("FAIL %s: got pc=%h addr=%h wr=%b gnt=%b blk=%b, want pc=%h addr=%h wr=%b gnt=%b blk=%b",
                 mon_e.name, pc, mem_address, mem_write, data_grant, block_fetch,
                 mon_e.pc, mon_e.addr, mon_e.wr, mon_e.gnt, mon_e.blk);
      end
    end
  end

  task automatic push(input int unsigned c, input string nm, input logic [31:0] epc,
                      input logic [31:0] eaddr, input logic ewr, input logic egnt,
                      input logic eblk);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.pc   = epc;
    e.addr = eaddr;
    e.wr   = ewr;
    e.gnt  = egnt;
    e.blk  = eblk;
    sb_q.push_back(e);
  endtask

  // Expectation applies to the outputs after the coming rising edge.
  task automatic tick(input string nm, input logic [31:0] epc, input logic [31:0] eaddr,
                      input logic ewr, input logic egnt, input logic eblk);
    push(cycle + 1, nm, epc, eaddr, ewr, egnt, eblk);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clock);
    #1;
    push(cycle, "reset_state", 32'h100, 32'h100, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Sequential fetch.
    inc_pc = 1'b1;
    tick("inc_104", 32'h104, 32'h104, 1'b0, 1'b0, 1'b0);
    tick("inc_108", 32'h108, 32'h108, 1'b0, 1'b0, 1'b0);
    tick("inc_10c", 32'h10C, 32'h10C, 1'b0, 1'b0, 1'b0);

    // Branch with unaligned target; inc_pc held high is ignored during FLUSH.
    branch_taken = 1'b1; branch_target = 32'h2003; inc_pc = 1'b0;
    tick("br_redirect", 32'h2000, 32'h2000, 1'b0, 1'b0, 1'b1);
    branch_taken = 1'b0; inc_pc = 1'b1;
    tick("br_flush1", 32'h2000, 32'h2000, 1'b0, 1'b0, 1'b1);
    tick("br_flush_end", 32'h2000, 32'h2000, 1'b0, 1'b0, 1'b0);
    tick("br_inc", 32'h2004, 32'h2004, 1'b0, 1'b0, 1'b0);

    // Move to pc = 0x40.
    inc_pc = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    tick("br40", 32'h40, 32'h40, 1'b0, 1'b0, 1'b1);
    branch_taken = 1'b0;
    tick("br40_f1", 32'h40, 32'h40, 1'b0, 1'b0, 1'b1);
    tick("br40_f2", 32'h40, 32'h40, 1'b0, 1'b0, 1'b0);

    // Single store.
    data_req = 1'b1; data_addr = 32'h8000; data_write = 1'b1;
    tick("store_grant", 32'h40, 32'h8000, 1'b1, 1'b1, 1'b1);
    data_req = 1'b0; data_write = 1'b0;
    tick("store_recov", 32'h40, 32'h40, 1'b0, 1'b0, 1'b1);
    tick("store_run", 32'h40, 32'h40, 1'b0, 1'b0, 1'b0);

    // Back-to-back load then store.
    data_req = 1'b1; data_addr = 32'h8004; data_write = 1'b0;
    tick("b2b_load", 32'h40, 32'h8004, 1'b0, 1'b1, 1'b1);
    data_addr = 32'h8008; data_write = 1'b1;
    tick("b2b_store", 32'h40, 32'h8008, 1'b1, 1'b1, 1'b1);
    data_req = 1'b0; data_write = 1'b0;
    tick("b2b_recov", 32'h40, 32'h40, 1'b0, 1'b0, 1'b1);
    tick("b2b_run", 32'h40, 32'h40, 1'b0, 1'b0, 1'b0);

    // Simultaneous branch and data_req: branch first, grant after FLUSH.
    branch_taken = 1'b1; branch_target = 32'h300;
    data_req = 1'b1; data_addr = 32'h9000; data_write = 1'b0;
    tick("sim_redirect", 32'h300, 32'h300, 1'b0, 1'b0, 1'b1);
    branch_taken = 1'b0;
    tick("sim_flush1", 32'h300, 32'h300, 1'b0, 1'b0, 1'b1);
    tick("sim_flush_end", 32'h300, 32'h300, 1'b0, 1'b0, 1'b0);
    tick("sim_grant", 32'h300, 32'h9000, 1'b0, 1'b1, 1'b1);
    data_req = 1'b0;
    tick("sim_recov", 32'h300, 32'h300, 1'b0, 1'b0, 1'b1);
    tick("sim_run", 32'h300, 32'h300, 1'b0, 1'b0, 1'b0);

    // Branch inside FLUSH restarts the counter; then wrap of pc.
    branch_taken = 1'b1; branch_target = 32'h1000;
    tick("rebr_a", 32'h1000, 32'h1000, 1'b0, 1'b0, 1'b1);
    branch_target = 32'hFFFF_FFFF;
    tick("rebr_b", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
    branch_taken = 1'b0;
    tick("rebr_f1", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
    tick("rebr_end", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    inc_pc = 1'b1;
    tick("wrap", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Halt for four cycles with inc_pc high.
    halt = 1'b1;
`ifdef FETCH_HALT_EN
    tick("halt1", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick("halt2", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick("halt3", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick("halt4", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    halt = 1'b0; inc_pc = 1'b0;
    tick("halt_exit", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
`else
    tick("nohalt1", 32'h4, 32'h4, 1'b0, 1'b0, 1'b0);
    tick("nohalt2", 32'h8, 32'h8, 1'b0, 1'b0, 1'b0);
    tick("nohalt3", 32'hC, 32'hC, 1'b0, 1'b0, 1'b0);
    tick("nohalt4", 32'h10, 32'h10, 1'b0, 1'b0, 1'b0);
    halt = 1'b0; inc_pc = 1'b0;
    tick("nohalt_idle", 32'h10, 32'h10, 1'b0, 1'b0, 1'b0);
`endif

    // Reset asserted mid-FLUSH, between clock edges.
    branch_taken = 1'b1; branch_target = 32'h500;
    tick("pre_rst_br", 32'h500, 32'h500, 1'b0, 1'b0, 1'b1);
    branch_taken = 1'b0;
    push(cycle + 1, "async_reset", 32'h100, 32'h100, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick("rst_hold", 32'h100, 32'h100, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick("rst_release", 32'h100, 32'h100, 1'b0, 1'b0, 1'b0);

    // Branch during DATA: access not granted again.
    data_req = 1'b1; data_addr = 32'h8000; data_write = 1'b1;
    tick("bd_grant", 32'h100, 32'h8000, 1'b1, 1'b1, 1'b1);
    branch_taken = 1'b1; branch_target = 32'h600;
    tick("bd_redirect", 32'h600, 32'h600, 1'b0, 1'b0, 1'b1);
    branch_taken = 1'b0; data_req = 1'b0; data_write = 1'b0;
    tick("bd_flush1", 32'h600, 32'h600, 1'b0, 1'b0, 1'b1);
    tick("bd_flush_end", 32'h600, 32'h600, 1'b0, 1'b0, 1'b0);

    @(negedge clock);
    @(negedge clock);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_address_gen.md
# fetch_address_gen

Instruction-fetch initiator at the front of the pipeline: owns the program counter, drives the shared memory address bus, and tells the fetch stage when the word on `mem_data` is not a valid instruction. It consumes `inc_pc` from the fetch stage and drives `block_fetch` back to it. It also grants the bus to load/store accesses from the memory stage and redirects fetch on taken branches.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- `FLUSH_CYCLES`, 2, cycles `block_fetch` stays high after a branch redirect; legal range 1–15.

Ports:
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces reset state immediately.
- `inc_pc`  in  1  from the fetch stage; 1 = the instruction at `pc` was consumed.
- `branch_taken`  in  1  one-cycle pulse from the execute stage.
- `branch_target`  in  32  redirect byte address; bits [1:0] are ignored and treated as 0.
- `data_req`  in  1  memory-stage bus request; held high until `data_grant` is seen.
- `data_addr`  in  32  load/store byte address; word aligned.
- `data_write`  in  1  1 = store, 0 = load; qualifies `data_req`.
- `halt`  in  1  level; freezes fetch while high.
- `mem_address`  out  32  registered bus address; bits [1:0] always 0.
- `mem_write`  out  1  registered write strobe; only ever 1 in DATA.
- `data_grant`  out  1  registered; 1 for exactly the cycle the data access owns the bus.
- `block_fetch`  out  1  registered; 1 = the fetch stage must insert a NOP.
- `pc`  out  32  address of the instruction currently being fetched.

## Operation
- States: RUN, FLUSH, DATA, HALTED.
- Reset state: RUN, `pc` = `mem_address` = `RESET_PC`, `mem_write` = 0, `data_grant` = 0, `block_fetch` = 0, flush counter = 0.
- Per-cycle priority: `branch_taken` > `data_req` > `halt` > `inc_pc`.
- Branch, in any state: `pc` and `mem_address` <= target & ~3, counter <= `FLUSH_CYCLES`, `block_fetch` <= 1, `mem_write` <= 0, `data_grant` <= 0, next state FLUSH. A branch in FLUSH restarts the counter. A branch in DATA does not cancel the access already on the bus, but the request is not granted again.
- RUN + `data_req`: `mem_address` <= `data_addr`, `mem_write` <= `data_write`, `data_grant` <= 1, `block_fetch` <= 1, next state DATA. `pc` is held.
- DATA: if `data_req` is still high, grant again and stay in DATA (back-to-back accesses). Otherwise, `mem_address` <= `pc`, `mem_write` <= 0, `data_grant` <= 0, `block_fetch` <= 1 for one recovery cycle, next state RUN.
- RUN + `halt`: next state HALTED, `block_fetch` <= 1, `pc` held. HALTED exits to RUN when `halt` = 0. A pending `data_req` is still served from HALTED, and the block returns to HALTED afterwards.
- RUN + `inc_pc`: `pc` and `mem_address` <= `pc` + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0. `inc_pc` is ignored in every state other than RUN.
- FLUSH: the counter decrements each cycle. When it reaches 0, next state RUN and `block_fetch` <= 0. A `data_req` in FLUSH is deferred until RUN.
- Reset asserted mid-operation: all outputs return to their reset values asynchronously. Any in-flight data access is abandoned with no grant.

## Timing
- Every output is registered, so a response appears one clock after the input is sampled.
- Branch: the redirected `mem_address` is valid the cycle after the `branch_taken` sample. `block_fetch` stays high for `FLUSH_CYCLES` cycles, then drops.
- Data access: `data_grant` is high for one cycle per access. The requester must drop `data_req` in the cycle `data_grant` is seen, or it receives another grant.
- Simultaneous `branch_taken` and `data_req`: the branch wins, and the request stays pending until the next RUN.
- Fetch throughput: one instruction per clock in RUN with `inc_pc` continuously high.

## Configuration
- `FETCH_HALT_EN` defined: `halt` behaves as described above.
- `FETCH_HALT_EN` undefined: `halt` is ignored and HALTED is never entered. The port remains and is unused.

## Test plan
- Reset with `RESET_PC` = 32'h100, release reset, hold `inc_pc` = 1 for 3 cycles -> `mem_address` = 100, 104, 108, 10C; `block_fetch` = 0 throughout.
- Branch pulse, target 32'h2003, `FLUSH_CYCLES` = 2 -> `mem_address` = 32'h2000 next cycle; `block_fetch` = 1 for 2 cycles, then 0; `pc` then advances to 2004.
- In RUN at `pc` = 32'h40, store with `data_req` = 1, `data_addr` = 32'h8000, `data_write` = 1 -> one cycle with `mem_address` = 8000, `mem_write` = 1, `data_grant` = 1; then `mem_address` = 40; `pc` unchanged.
- Same-cycle `branch_taken` (target 32'h300) and `data_req` -> redirect to 32'h300 first; `data_grant` follows only after FLUSH completes.
- `pc` = 32'hFFFF_FFFC with `inc_pc` = 1 -> `pc` = 0.
- With `FETCH_HALT_EN` defined, assert `halt` for 4 cycles -> `block_fetch` = 1 and `pc` frozen; without the macro, `pc` keeps incrementing. Then drop `reset` mid-FLUSH -> all outputs return to their reset values immediately.
